// File: rtl/leds_pio_blink_if.sv
// Avalon-MM slave bus bundle for leds_pio_blink (word-addressed, zero wait states).
interface leds_pio_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/leds_pio_blink.sv
// LED output PIO with atomic set/clear/toggle and a per-bit blink engine.
// Optional feature macro: LEDS_PIO_PWM_EN adds BRIGHT (address 7) and a
// global 8-bit PWM dimmer applied to every output bit.
module leds_pio_blink #(
    parameter int              WIDTH       = 14,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              PRESCALE_W  = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    leds_pio_blink_if.slave    bus,
    output logic [WIDTH-1:0]   out_port
);
    localparam logic [PRESCALE_W-1:0] P_ONE = 1;

    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      r_mask;
    logic [PRESCALE_W-1:0] r_period;
    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_phase;
    logic [WIDTH-1:0]      r_out;

    logic                  w_wr;
    logic [WIDTH-1:0]      w_wd;
    logic [WIDTH-1:0]      w_out_next;
    logic                  w_pwm_on;
    logic [31:0]           w_readdata;
    logic                  w_unused_bits;

    assign w_wr = bus.chipselect && !bus.write_n;
    assign w_wd = bus.writedata[WIDTH-1:0];
    // Upper write-data bits are architecturally ignored.
    assign w_unused_bits = &{1'b0, bus.writedata};

`ifdef LEDS_PIO_PWM_EN
    logic [7:0] r_bright;
    logic [7:0] r_pwm_cnt;

    // Brightness register and free-running PWM counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bright  <= 8'hFF;
            r_pwm_cnt <= 8'h00;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_wr && bus.address == 3'd7)
                r_bright <= bus.writedata[7:0];
        end
    end

    // Full brightness must be a solid 100 %, not 255/256.
    assign w_pwm_on = (r_bright == 8'hFF) || (r_pwm_cnt < r_bright);
`else
    assign w_pwm_on = 1'b1;
`endif

    // DATA and BLINK_MASK updates, including atomic set/clear/toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
            r_mask <= '0;
        end else if (w_wr) begin
            case (bus.address)
                3'd0:    r_data <= w_wd;
                3'd1:    r_mask <= w_wd;
                3'd4:    r_data <= r_data | w_wd;
                3'd5:    r_data <= r_data & ~w_wd;
                3'd6:    r_data <= r_data ^ w_wd;
                default: ;
            endcase
        end
    end

    // Blink engine: any PERIOD write restarts the half-period from phase 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (w_wr && bus.address == 3'd2) begin
            r_period <= bus.writedata[PRESCALE_W-1:0];
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (r_period == '0) begin
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (r_cnt == r_period - P_ONE) begin
            r_cnt    <= '0;
            r_phase  <= ~r_phase;
        end else begin
            r_cnt    <= r_cnt + P_ONE;
        end
    end

    // Per-bit LED drive: blanked while its mask bit is set and phase is 1.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_out
            assign w_out_next[gi] = r_data[gi] & ~(r_mask[gi] & r_phase) & w_pwm_on;
        end
    endgenerate

    // Registered LED output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_out <= RESET_VALUE;
        else
            r_out <= w_out_next;
    end

    assign out_port = r_out;

    // Combinational read mux; write-only and reserved locations read 0.
    always_comb begin
        w_readdata = '0;
        case (bus.address)
            3'd0: w_readdata[WIDTH-1:0]      = r_data;
            3'd1: w_readdata[WIDTH-1:0]      = r_mask;
            3'd2: w_readdata[PRESCALE_W-1:0] = r_period;
            3'd3: w_readdata[0]              = r_phase;
`ifdef LEDS_PIO_PWM_EN
            3'd7: w_readdata[7:0]            = r_bright;
`endif
            default: w_readdata = '0;
        endcase
    end

    assign bus.readdata = w_readdata;
endmodule
